// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the MEM/WB pipeline register payload.
package mips_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_AW-1:0] dest;
        logic              mem_to_reg;
        logic              reg_write;
    } mem_wb_t;

endpackage : mips_pkg

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are not reset; they start at zero in simulation.
module data_memory
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : data_memory

// File: rtl/memory_stage.sv
// MIPS MEM stage: data-memory access plus the MEM/WB pipeline register.
// Optional MEM_ALIGN_CHECK_EN adds MisalignedErr and blocks misaligned accesses.
module memory_stage
    import mips_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [DATA_W-1:0] WriteData_in,
    input  logic [REG_AW-1:0] Address_in,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    output logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] ALUResult,
    output logic [REG_AW-1:0] Address,
    output logic              MemToReg,
    output logic              RegWrite
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              MisalignedErr
`endif
);

    logic [MEM_AW-1:0] word_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic              capture;
    logic              misaligned_c;
    logic              mem_we;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;

    // Byte address to word index; upper bits wrap, low two bits dropped.
    assign word_idx = ALUResult_in[MEM_AW+1:2];
    assign capture  = !Rst && !Flush && !Stall;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned_c = (MemRead || MemWrite) && (ALUResult_in[1:0] != 2'b00);
`else
    assign misaligned_c = 1'b0;
`endif

    assign mem_we = MemWrite && capture && !misaligned_c;

    data_memory u_dmem (
        .clk     (Clk),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .wdata_i (WriteData_in),
        .rdata_o (mem_rdata)
    );

    // Flush inserts a bubble, Stall holds, otherwise capture the instruction.
    always_comb begin
        wb_d = wb_q;
        if (Flush) begin
            wb_d = '0;
        end else if (!Stall) begin
            wb_d.read_data  = MemRead ? mem_rdata : DATA_W'(0);
            wb_d.alu_result = ALUResult_in;
            wb_d.dest       = Address_in;
            wb_d.mem_to_reg = MemToReg_in;
            wb_d.reg_write  = RegWrite_in && !misaligned_c;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign ReadData  = wb_q.read_data;
    assign ALUResult = wb_q.alu_result;
    assign Address   = wb_q.dest;
    assign MemToReg  = wb_q.mem_to_reg;
    assign RegWrite  = wb_q.reg_write;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_d;
    logic misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (Flush) begin
            misalign_d = 1'b0;
        end else if (!Stall) begin
            misalign_d = misaligned_c;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign MisalignedErr = misalign_q;
`endif

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// Directed + light random bench for memory_stage with a scoreboard queue.
module tb_memory_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush;
    logic [31:0] ALUResult_in, WriteData_in;
    logic [4:0]  Address_in;
    logic        MemRead, MemWrite, MemToReg_in, RegWrite_in;
    logic [31:0] ReadData, ALUResult;
    logic [4:0]  Address;
    logic        MemToReg, RegWrite;
`ifdef MEM_ALIGN_CHECK_EN
    logic        MisalignedErr;
`endif

    always #5 Clk = ~Clk;

    memory_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .Flush        (Flush),
        .ALUResult_in (ALUResult_in),
        .WriteData_in (WriteData_in),
        .Address_in   (Address_in),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemToReg_in  (MemToReg_in),
        .RegWrite_in  (RegWrite_in),
        .ReadData     (ReadData),
        .ALUResult    (ALUResult),
        .Address      (Address),
        .MemToReg     (MemToReg),
        .RegWrite     (RegWrite)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .MisalignedErr(MisalignedErr)
`endif
    );

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        mtr;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [31:0] mmem [int unsigned];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mread(input int unsigned idx);
        return mmem.exists(idx) ? mmem[idx] : 32'd0;
    endfunction

    // Drive one instruction, predict the MEM/WB contents, compare after the edge.
    task automatic step(input string tag, input bit rst, input bit stall, input bit flush,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                        input bit mr, input bit mw, input bit mtr, input bit rw);
        exp_t        nxt;
        exp_t        e;
        int unsigned idx;
        bit          mis;
        logic [70:0] obs;
        logic [70:0] expv;
        @(negedge Clk);
        Rst = rst; Stall = stall; Flush = flush;
        ALUResult_in = alu; WriteData_in = wd; Address_in = dst;
        MemRead = mr; MemWrite = mw; MemToReg_in = mtr; RegWrite_in = rw;
        idx = int'(alu[11:2]);
`ifdef MEM_ALIGN_CHECK_EN
        mis = (mr || mw) && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (rst || flush) begin
            nxt = '0;
        end else if (stall) begin
            nxt = cur;
        end else begin
            nxt.rd   = mr ? mread(idx) : 32'd0;
            nxt.alu  = alu;
            nxt.dest = dst;
            nxt.mtr  = mtr;
            nxt.rw   = rw && !mis;
            nxt.mis  = mis;
            if (mw && !mis) mmem[idx] = wd;
        end
        cur = nxt;
        sb_q.push_back(nxt);
        @(posedge Clk);
        #1;
        e    = sb_q.pop_front();
        obs  = {ReadData, ALUResult, Address, MemToReg, RegWrite};
        expv = {e.rd, e.alu, e.dest, e.mtr, e.rw};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        assert (MisalignedErr === e.mis) else begin
            errors++;
            $error("FAIL %s_mis observed=%b expected=%b", tag, MisalignedErr, e.mis);
        end
`endif
    endtask

    initial begin
        cur = '0;
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        ALUResult_in = '0; WriteData_in = '0; Address_in = '0;
        MemRead = 1'b0; MemWrite = 1'b0; MemToReg_in = 1'b0; RegWrite_in = 1'b0;

        // Reset with random traffic, including a store to word 0 that must be dropped
        step("reset0", 1, $urandom_range(0,1), $urandom_range(0,1), 32'h0, $urandom, 5'($urandom),
             1, 1, 1, 1);
        step("reset1", 1, $urandom_range(0,1), 0, $urandom, $urandom, 5'($urandom),
             $urandom_range(0,1), 0, 1, 1);
        step("mem0_unchanged", 0, 0, 0, 32'h0, 32'h0, 5'd1, 1, 0, 1, 1);

        step("store_beef", 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0);
        step("load_beef", 0, 0, 0, 32'h10, 32'h0, 5'd8, 1, 0, 1, 1);
        step("rtype", 0, 0, 0, 32'h12345678, 32'hFFFF_FFFF, 5'd3, 0, 0, 0, 1);

        // Stall: hold outputs, stores suppressed
        step("stall0", 0, 1, 0, 32'h20, 32'h55, 5'd9, 0, 1, 1, 1);
        step("stall1", 0, 1, 0, 32'h20, 32'h55, 5'd10, 1, 1, 0, 1);
        step("stall2", 0, 1, 0, 32'h20, 32'h55, 5'd11, 0, 1, 1, 0);
        step("mem8_unchanged", 0, 0, 0, 32'h20, 32'h0, 5'd12, 1, 0, 1, 1);
        step("store_55", 0, 0, 0, 32'h20, 32'h55, 5'd0, 0, 1, 0, 0);
        step("load_55", 0, 0, 0, 32'h20, 32'h0, 5'd13, 1, 0, 1, 1);

        // Flush: bubble and dropped store; flush beats stall
        step("flush", 0, 0, 1, 32'h4, 32'hAA, 5'd14, 0, 1, 1, 1);
        step("load_after_flush", 0, 0, 0, 32'h4, 32'h0, 5'd15, 1, 0, 1, 1);
        step("flush_over_stall", 0, 1, 1, 32'h4, 32'hAB, 5'd16, 0, 1, 1, 1);

        // Address wrap modulo MEM_DEPTH words
        step("store_wrap", 0, 0, 0, 32'h1004, 32'h77, 5'd0, 0, 1, 0, 0);
        step("load_wrap", 0, 0, 0, 32'h4, 32'h0, 5'd17, 1, 0, 1, 1);
        step("load_unaligned", 0, 0, 0, 32'h6, 32'h0, 5'd18, 1, 0, 1, 1);
        step("hold_after_unal", 0, 1, 0, 32'h8, 32'h0, 5'd19, 1, 0, 1, 1);
        step("store_unaligned", 0, 0, 0, 32'h4002, 32'h66, 5'd0, 0, 1, 0, 1);
        step("load_after_unal", 0, 0, 0, 32'h4, 32'h0, 5'd20, 1, 0, 1, 1);

        // Illegal read+write: store happens, old word is returned
        step("rw_both", 0, 0, 0, 32'h30, 32'h99, 5'd21, 1, 1, 1, 1);
        step("load_30", 0, 0, 0, 32'h30, 32'h0, 5'd22, 1, 0, 1, 1);

        // Reset mid-operation drops the store
        step("rst_store", 1, 0, 0, 32'h40, 32'h123, 5'd23, 0, 1, 1, 1);
        step("load_40", 0, 0, 0, 32'h40, 32'h0, 5'd24, 1, 0, 1, 1);

        // Short random mix over a small address window
        for (int i = 0; i < 24; i++) begin
            bit          mr, mw;
            logic [31:0] a;
            mr = $urandom_range(0, 1);
            mw = mr ? 1'b0 : 1'($urandom_range(0, 1));
            a  = 32'h100 + 32'(4 * $urandom_range(0, 3));
            step($sformatf("rand%0d", i), 0, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), a, $urandom, 5'($urandom), mr, mw,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_memory_stage
